// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: read-mode encodings
// and the byte-lane helper used to size write-port 3's byte enables.
package regfile_mp_pkg;

  localparam int RF_RD_COMB = 0;
  localparam int RF_RD_REG  = 1;

  function automatic int byte_lanes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/regfile_mp_rdport.sv
// One read port: selects the post-write word for its address and optionally
// registers it, giving write-first behaviour in both read modes.
module regfile_mp_rdport
  import regfile_mp_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int READ_REG = RF_RD_COMB,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra,
  input  logic [WIDTH-1:0] words [DEPTH],
  output logic [WIDTH-1:0] rd
);

  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] rd_q;

  // The words already carry this cycle's merged writes, so a plain mux is the bypass.
  assign word = words[ra];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
    end else begin
      // NOTE: non-blocking for every clocked state so all flops sample the same pre-edge values.
      rd_q <= word;
    end
  end

  // In combinational mode rd_q has no load and is pruned by synthesis.
  assign rd = (READ_REG == RF_RD_REG) ? rd_q : word;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: two write ports (port 3 byte-enabled and winning
// collisions per byte), NREAD write-first read ports, optional zero register.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int READ_REG = 0,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int NB      = byte_lanes(WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we3,
  input  logic [AW-1:0]          a3,
  input  logic [WIDTH-1:0]       wd3,
  input  logic [NB-1:0]          be3,
  input  logic                   we4,
  input  logic [AW-1:0]          a4,
  input  logic [WIDTH-1:0]       wd4,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd
);

  logic [WIDTH-1:0] mem      [DEPTH];
  logic [WIDTH-1:0] next_mem [DEPTH];

  // Post-write value of every register: port 4 first, then port 3's enabled
  // bytes on top, so port 3 wins per byte on a collision.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      // NOTE: blocking in combinational logic, with a default first so no latch is inferred.
      next_mem[i] = mem[i];
      if (we4 && a4 == AW'(i)) next_mem[i] = wd4;
      if (we3 && a3 == AW'(i)) begin
        for (int b = 0; b < NB; b++) begin
          if (be3[b]) next_mem[i][8*b +: 8] = wd3[8*b +: 8];
        end
      end
      if (ZERO_REG != 0 && i == 0) next_mem[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the whole array is cleared asynchronously, so it is built from flops, not a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= next_mem[i];
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    regfile_mp_rdport #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .READ_REG(READ_REG)
    ) u_rdport (
      .clk  (clk),
      .reset(reset),
      .ra   (ra[k*AW +: AW]),
      .words(next_mem),
      .rd   (rd[k*WIDTH +: WIDTH])
    );
  end

endmodule
